// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared RV32M sizes, funct3 codes and sequencer state type
package muldiv_seq_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;
    localparam logic [6:0] F7_R_M   = 7'b0000001;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
endpackage

// File: rtl/muldiv_iter_dp.sv
// muldiv_iter_dp: operand/accumulator registers and one-step shift-add / restoring-divide datapath
// Ports: load latches magnitudes and sign flags from f3/a/b; load_sp writes sp_val straight
// into result; step runs one iteration; fix applies signs and registers the selected result.
module muldiv_iter_dp
    import muldiv_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            load_sp,
    input  logic            step,
    input  logic            fix,
    input  logic [2:0]      f3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] sp_val,
    output logic [XLEN-1:0] result
);
    logic [2:0]        op;
    logic [XLEN-1:0]   opnd, am, bm, rem, res_sel;
    logic [2*XLEN-1:0] acc, acc_nx, prod;
    logic [XLEN:0]     mul_sum, sh, diff;
    logic              a_neg, b_neg, neg_q, neg_r, qb;
    // opnd holds the multiplicand (mul) or divisor (div); acc low half starts as the
    // multiplier (consumed LSB-first) or the dividend (shifted out as quotient bits enter)
    always_comb begin
        a_neg   = a[XLEN-1] && (f3 == F_MULH || f3 == F_MULHSU || f3 == F_DIV || f3 == F_REM);
        b_neg   = b[XLEN-1] && (f3 == F_MULH || f3 == F_DIV || f3 == F_REM);
        am      = a_neg ? -a : a;
        bm      = b_neg ? -b : b;
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        sh      = acc[2*XLEN-1:XLEN-1];
        diff    = sh - {1'b0, opnd};
        qb      = !diff[XLEN];
        acc_nx  = op[2] ? {qb ? diff[XLEN-1:0] : sh[XLEN-1:0], acc[XLEN-2:0], qb}
                        : {mul_sum, acc[XLEN-1:1]};
        // the low half of the negated product is also the negated quotient
        prod    = neg_q ? -acc : acc;
        rem     = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        res_sel = !op[2] ? (op == F_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                         : (op[1] ? rem : prod[XLEN-1:0]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op     <= '0;
            opnd   <= '0;
            acc    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            if (load) begin
                op    <= f3;
                opnd  <= f3[2] ? bm : am;
                acc   <= {{XLEN{1'b0}}, f3[2] ? am : bm};
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
            end else if (step) begin
                acc <= acc_nx;
            end
            if (fix)
                result <= res_sel;
            else if (load_sp)
                result <= sp_val;
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M multiply/divide sequencer with pipeline stall
// Ports: start/funct3_/rs1_value/rs2_value request an operation (sampled in IDLE);
// kill aborts CALC/FIX; stall_ freezes the front end; busy = not IDLE; done pulses
// for one cycle with result valid; result holds until the next accepted start.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3_,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    input  logic            kill,
    output logic            stall_,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    state_t          state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic            accept, div_zero, div_ovf, special;
    logic [XLEN-1:0] sp_val;
    always_comb begin
        accept   = state == IDLE && start && !kill;
        div_zero = funct3_[2] && rs2_value == '0;
        div_ovf  = (funct3_ == F_DIV || funct3_ == F_REM) && rs2_value == '1 &&
                   rs1_value == {1'b1, {(XLEN-1){1'b0}}};
        special  = div_zero || div_ovf;
        // overflow quotient equals the dividend itself (0x80000000)
        sp_val   = div_zero ? (funct3_[1] ? rs1_value : '1) : (funct3_[1] ? '0 : rs1_value);
        case (state)
            IDLE:    state_nx = accept ? (special ? DONE : CALC) : IDLE;
            CALC:    state_nx = kill ? IDLE : (cnt == CNT_W'(1) ? FIX : CALC);
            FIX:     state_nx = kill ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
        stall_ = accept || state == CALC || state == FIX;
        busy   = state != IDLE;
        done   = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= accept ? CNT_W'(XLEN) : (state == CALC ? cnt - CNT_W'(1) : cnt);
        end
    end
    muldiv_iter_dp u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept && !special),
        .load_sp(accept && special),
        .step   (state == CALC && !kill),
        .fix    (state == FIX && !kill),
        .f3     (funct3_),
        .a      (rs1_value),
        .b      (rs2_value),
        .sp_val (sp_val),
        .result (result)
    );
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: randomized and directed check of muldiv_seq against an arithmetic model
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;
    logic        clk = 0, rst_n = 0, start = 0, kill = 0;
    logic [2:0]  funct3_ = '0;
    logic [31:0] rs1_value = '0, rs2_value = '0;
    logic        stall_, busy, done;
    logic [31:0] result;
    int          n_tests = 0, n_fail = 0, cyc = 0, exp_at = 0;
    logic        exp_pend = 0;
    logic [31:0] exp_res = '0, last_res = '0;

    muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3_(funct3_),
        .rs1_value(rs1_value), .rs2_value(rs2_value), .kill(kill),
        .stall_(stall_), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r = '0;
        case (f)
            F_MUL:    begin p = ua * ub; r = p[31:0]; end
            F_MULH:   begin p = sa * sb; r = p[63:32]; end
            F_MULHSU: begin p = sa * ub; r = p[63:32]; end
            F_MULHU:  begin p = ua * ub; r = p[63:32]; end
            F_DIV:    if (b == 0) r = '1; else begin p = sa / sb; r = p[31:0]; end
            F_DIVU:   if (b == 0) r = '1; else begin p = ua / ub; r = p[31:0]; end
            F_REM:    if (b == 0) r = a;  else begin p = sa % sb; r = p[31:0]; end
            default:  if (b == 0) r = a;  else begin p = ua % ub; r = p[31:0]; end
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    endfunction

    // compare process: done must appear exactly when the model expects it, with the
    // model's value; otherwise result must hold its last delivered value
    always @(negedge clk) begin
        if (!rst_n)
            last_res = '0;
        else if (done || (exp_pend && cyc == exp_at)) begin
            chk("done_cycle", 32'(done && exp_pend && cyc == exp_at), 32'd1);
            if (done)
                chk("result", result, exp_res);
            last_res = result;
            exp_pend = 0;
        end else
            chk("result_hold", result, last_res);
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit poke);
        int t;
        bit sp;
        t = 0;
        @(negedge clk);
        while (busy && t < 100) begin @(negedge clk); t++; end
        sp = is_special(f, a, b);
        start = 1; funct3_ = f; rs1_value = a; rs2_value = b;
        exp_res = model(f, a, b);
        exp_at = cyc + (sp ? 1 : 34);
        exp_pend = 1;
        #1 chk("stall_start", 32'(stall_), 32'd1);
        @(negedge clk);
        start = 0;
        chk("stall_next", 32'(stall_), 32'(!sp));
        t = 0;
        while (exp_pend && t < 60) begin
            if (poke && t == 3) begin start = 1; funct3_ = F_MULHU; rs1_value = '1; end
            if (poke && t == 6) start = 0;
            @(negedge clk);
            t++;
        end
        if (exp_pend) begin chk("done_timeout", 32'd0, 32'd1); exp_pend = 0; end
    endtask

    task automatic pin(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit);
        chk("model_pin", model(f, a, b), lit);
        run_op(f, a, b, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall_), 32'd0);
        chk("rst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        pin(F_MULH, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
        pin(F_MUL,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA);
        pin(F_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        pin(F_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        pin(F_DIVU, 32'd100, 32'd7, 32'd14);
        pin(F_REMU, 32'd100, 32'd7, 32'd2);
        pin(F_DIV,  32'd5, 32'd0, 32'hFFFFFFFF);
        pin(F_REMU, 32'd5, 32'd0, 32'd5);
        pin(F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        pin(F_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0);
        pin(F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // kill mid-operation: accepted at edge 0, kill during cycle 10, idle in cycle 11
        @(negedge clk);
        start = 1; funct3_ = F_MULHU; rs1_value = '1; rs2_value = '1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        kill = 1;
        @(negedge clk);
        kill = 0;
        chk("kill_busy", 32'(busy), 32'd0);
        chk("kill_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        pin(F_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);

        // start together with kill in IDLE is ignored
        @(negedge clk);
        start = 1; kill = 1; funct3_ = F_MUL;
        #1 chk("kill_idle_stall", 32'(stall_), 32'd0);
        @(negedge clk);
        start = 0; kill = 0;
        chk("kill_idle_busy", 32'(busy), 32'd0);

        // starts during CALC are not queued: exactly one done
        run_op(F_DIVU, 32'd1000, 32'd9, 1);
        repeat (40) @(negedge clk);

        // async reset during CALC clears everything immediately
        @(negedge clk);
        start = 1; funct3_ = F_MUL; rs1_value = 32'd12; rs2_value = 32'd12;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_stall", 32'(stall_), 32'd0);
        chk("arst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 80; i++)
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
